// File: rtl/fp_pkg.sv
// Shared defaults and helpers for the Q-format vector multiplier.
package fp_pkg;

    localparam int unsigned N_DEF = 16;
    localparam int unsigned Q_DEF = 12;

    // Saturation limits for the default operand width
    localparam logic [N_DEF-1:0] SAT_MAX = {1'b0, {(N_DEF-1){1'b1}}};
    localparam logic [N_DEF-1:0] SAT_MIN = {1'b1, {(N_DEF-1){1'b0}}};

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/fp_mul_lane.sv
// One signed Q-format multiplier slot: full-width product, optional
// half-up rounding, arithmetic rescale, overflow detect and saturation.
module fp_mul_lane
    import fp_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned Q = Q_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         round_en,
    input  logic         sat_en,
    output logic [N-1:0] result,
    output logic         ovf
);

    localparam int unsigned PW = 2 * N;
    localparam logic signed [PW-1:0] RND_BIAS = PW'(1) << (Q - 1);
    localparam logic [N-1:0] L_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] L_MIN = {1'b1, {(N-1){1'b0}}};

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_biased;
    logic signed [PW-1:0] w_shift;

    // Product never reaches 2^(2N-1), so the rounding bias cannot wrap
    always_comb begin
        w_prod   = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
        w_biased = w_prod + (round_en ? RND_BIAS : '0);
        w_shift  = w_biased >>> Q;
        // Fits in N bits only if every bit above the sign matches it
        ovf      = (w_shift[PW-1:N-1] != {(N+1){w_shift[N-1]}});
        if (sat_en && ovf) begin
            result = w_shift[PW-1] ? L_MIN : L_MAX;
        end else begin
            result = w_shift[N-1:0];
        end
    end

endmodule

// File: rtl/multiplier_fp_vec_seq.sv
// LANES-wide Q-format multiplier sharing PAR lane units over BEATS cycles,
// with start/busy/done handshake and registered results.
module multiplier_fp_vec_seq
    import fp_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned Q     = Q_DEF,
    parameter int unsigned LANES = 9,
    parameter int unsigned PAR   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               round_en,
    input  logic               sat_en,
    input  logic [LANES*N-1:0] a_vec,
    input  logic [LANES*N-1:0] b_vec,
    output logic [LANES*N-1:0] o_vec,
    output logic [LANES-1:0]   ovf_vec,
    output logic               busy,
    output logic               done
);

    localparam int unsigned BEATS = ceil_div(LANES, PAR);
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [BW-1:0]      r_beat;
    logic [LANES*N-1:0] r_a;
    logic [LANES*N-1:0] r_b;
    logic               r_round;
    logic               r_sat;
    logic [LANES*N-1:0] r_o;
    logic [LANES-1:0]   r_ovf;
    logic               r_done;

    logic [PAR-1:0][N-1:0] w_a_sel;
    logic [PAR-1:0][N-1:0] w_b_sel;
    logic [PAR-1:0][N-1:0] w_res;
    logic [PAR-1:0]        w_ovf;
    logic [PAR-1:0]        w_wr_en;
    int unsigned           w_idx [PAR];

    // Route the lanes of the current beat to the multiplier slots
    always_comb begin
        for (int unsigned k = 0; k < PAR; k++) begin
            w_idx[k]   = 32'(r_beat) * PAR + k;
            w_wr_en[k] = (w_idx[k] < LANES);
            w_a_sel[k] = '0;
            w_b_sel[k] = '0;
            if (w_wr_en[k]) begin
                w_a_sel[k] = r_a[w_idx[k]*N +: N];
                w_b_sel[k] = r_b[w_idx[k]*N +: N];
            end
        end
    end

    for (genvar g = 0; g < PAR; g++) begin : g_lane
        fp_mul_lane #(
            .N (N),
            .Q (Q)
        ) u_lane (
            .a        (w_a_sel[g]),
            .b        (w_b_sel[g]),
            .round_en (r_round),
            .sat_en   (r_sat),
            .result   (w_res[g]),
            .ovf      (w_ovf[g])
        );
    end

    // Handshake FSM, operand latches and per-beat result write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_round <= 1'b0;
            r_sat   <= 1'b0;
            r_o     <= '0;
            r_ovf   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a_vec;
                        r_b     <= b_vec;
                        r_round <= round_en;
                        r_sat   <= sat_en;
                        r_ovf   <= '0;
                        r_beat  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Slots past LANES on a partial last beat are dropped
                    for (int unsigned k = 0; k < PAR; k++) begin
                        if (w_wr_en[k]) begin
                            r_o[w_idx[k]*N +: N] <= w_res[k];
                            r_ovf[w_idx[k]]      <= w_ovf[k];
                        end
                    end
                    if (r_beat == BW'(BEATS - 1)) begin
                        r_beat  <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_vec   = r_o;
    assign ovf_vec = r_ovf;
    assign busy    = r_state;
    assign done    = r_done;

endmodule

// File: doc/multiplier_fp_vec_seq.md
Name: multiplier_fp_vec_seq

Overview:
Parametrised successor to the fixed 9-lane Q-format multiplier array. Multiplies LANES signed fixed-point operand pairs using PAR physical multipliers, time-multiplexed over ceil(LANES/PAR) beats. Adds selectable rounding, saturation and per-lane overflow flags, with a start/busy/done handshake. Feeds the VAE layer datapath wherever element-wise Q-format products are required.

Parameters:
N, 16, operand/result width (signed two's complement)
Q, 12, fractional bits; legal range 1 <= Q < N
LANES, 9, number of operand pairs per operation
PAR, 3, physical multipliers; legal range 1 <= PAR <= LANES
BEATS (localparam), ceil(LANES/PAR), compute cycles per operation

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; accepted only when busy==0
round_en  in  1  1 = round half-up, 0 = truncate (floor); latched on accept
sat_en  in  1  1 = saturate, 0 = wrap to low N bits; latched on accept
a_vec  in  LANES*N  operands, lane i at [i*N +: N]; latched on accept
b_vec  in  LANES*N  operands, same packing
o_vec  out  LANES*N  results, same packing
ovf_vec  out  LANES  per-lane overflow flag
busy  out  1  operation in progress
done  out  1  one-cycle pulse, results valid

Behaviour:
- Reset (async, any time, including mid-operation): busy=0, done=0, o_vec=0, ovf_vec=0, beat counter=0, operand/mode latches cleared. In-flight operation is discarded.
- FSM states: IDLE and RUN.
  - IDLE: start=1 at an edge captures a_vec, b_vec, round_en and sat_en, clears ovf_vec, sets busy=1 and beat=0, and goes to RUN.
  - RUN: at each edge, lanes beat*PAR .. min(beat*PAR+PAR, LANES)-1 are written to o_vec/ovf_vec and beat increments. At the edge that writes beat BEATS-1: busy=0, done=1, go to IDLE.
- Latency: done rises exactly BEATS edges after the accept edge and stays high for one cycle. Defaults give BEATS=3.
- start while busy=1 is ignored, with no queuing. This includes the edge that completes the operation. Earliest back-to-back accept is the edge after done rises, i.e. throughput is one operation per BEATS+1 cycles.
- Input changes after accept have no effect on the operation in progress.
- o_vec lanes not yet written during RUN keep their previous-operation values. Only the done cycle guarantees a coherent vector. o_vec holds after done until the next operation overwrites it.
- Partial last beat (LANES mod PAR != 0): unused multiplier slots are computed but never written.
- Per-lane arithmetic:
  - p = signed(a)*signed(b), full 2N bits.
  - If round_en: p += 2^(Q-1).
  - r = p >>> Q (arithmetic shift).
  - ovf = r outside [-2^(N-1), 2^(N-1)-1]. The flag is set regardless of sat_en.
  - Result: if sat_en and ovf, clamp to 0x7FFF.. or 0x8000.. according to sign; otherwise r[N-1:0].
- No combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- Shared package fp_pkg holds the N/Q defaults, the SAT_MAX/SAT_MIN constants derived from N, and a function for ceil division used for BEATS.
- Natural sub-module: fp_mul_lane.
  - Purely combinational; parameters N and Q.
  - Ports: a, b, round_en, sat_en -> result, ovf.
  - Instantiated PAR times.
- Top level contains the FSM, beat counter, operand latches, lane muxing (operand select by beat) and output registers.

Test Plan:
1. Defaults; lane0 0x2000*0x3000 (2.0*3.0) and lane1 0xE800*0x2000 (-1.5*2.0), other lanes 0. Pulse start. -> done exactly 3 cycles after the accept edge; o lane0=0x6000, lane1=0xD000, others 0, ovf_vec=0.
2. Lane4 0x0001*0x0800. With round_en=0 -> 0x0000. With round_en=1 -> 0x0001. Lane5 0xFFFF*0x0800: round_en=0 -> 0xFFFF, round_en=1 -> 0x0000.
3. Lane8 0x4000*0x4000 (4.0*4.0). With sat_en=1 -> 0x7FFF and ovf[8]=1. With sat_en=0 -> 0x0000 and ovf[8]=1. For 0x4000*0xC000 with sat_en=1 -> 0x8000 and ovf=1.
4. Hold start high continuously for 12 cycles -> accepts at cycles 0, 4 and 8; busy pattern 1,1,1,0 repeating; exactly 3 done pulses. Inputs changed mid-RUN must not alter results.
5. Assert rst asynchronously (between edges) during beat 1 -> busy, done, o_vec and ovf_vec all 0 immediately. A new start after rst deasserts completes normally.
6. Parameter sweep with LANES=5, PAR=2 (BEATS=3, partial last beat) and with PAR=LANES=9 (BEATS=1): random vectors checked against a reference model; done latency must equal BEATS.
